// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller: FSM states, opcodes,
// ALU operation codes and datapath mux selects.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECUTE = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    ADDIEX  = 4'd9,
    ANDIEX  = 4'd10,
    IMMWB   = 4'd11,
    JUMP    = 4'd12
  } statetype_t;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_J     = 6'b000010;

  // aludec decodes these values directly; do not renumber
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_AND   = 2'b10;
  localparam logic [1:0] ALUOP_FUNCT = 2'b11;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  function automatic logic op_supported(input logic [5:0] op);
    case (op)
      OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_ANDI, OP_J: return 1'b1;
      default:                                                return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_maindec_if.sv
// Control bundle between the main decoder and the multicycle datapath.
// master = mc_maindec (consumes op, drives controls); slave = datapath side.
interface mc_maindec_if;
  import mc_ctrl_pkg::*;

  logic [5:0] op;
  logic       pcwrite;
  logic       memwrite;
  logic       irwrite;
  logic       regwrite;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic       branch;
  logic       iord;
  logic       memtoreg;
  logic       regdst;
  logic       zeroext;
  logic [1:0] pcsrc;
  logic [1:0] aluop;
  logic       illegal_op;
  logic [3:0] state;

  modport master (
    input  op,
    output pcwrite, memwrite, irwrite, regwrite, alusrca, alusrcb, branch,
           iord, memtoreg, regdst, zeroext, pcsrc, aluop, illegal_op, state
  );

  modport slave (
    output op,
    input  pcwrite, memwrite, irwrite, regwrite, alusrca, alusrcb, branch,
           iord, memtoreg, regdst, zeroext, pcsrc, aluop, illegal_op, state
  );

endinterface

// File: rtl/mc_maindec.sv
// Main Moore FSM of the multicycle MIPS controller: sequences fetch, decode,
// execute and writeback. Outputs decode from state only, except illegal_op.
module mc_maindec
  import mc_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  mc_maindec_if.master    ctl
);

  statetype_t state_q;
  statetype_t state_d;

  always_ff @(posedge clk) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:   state_d = DECODE;
      DECODE: begin
        case (ctl.op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = EXECUTE;
          OP_BEQ:       state_d = BRANCH;
          OP_ADDI:      state_d = ADDIEX;
          OP_ANDI:      state_d = ANDIEX;
          OP_J:         state_d = JUMP;
          default:      state_d = FETCH;
        endcase
      end
      // only lw/sw reach MEMADR, so anything other than sw is a load
      MEMADR:  state_d = (ctl.op == OP_SW) ? MEMWR : MEMRD;
      MEMRD:   state_d = MEMWB;
      EXECUTE: state_d = ALUWB;
      ADDIEX:  state_d = IMMWB;
      ANDIEX:  state_d = IMMWB;
      default: state_d = FETCH;
    endcase
  end

  always_comb begin
    ctl.pcwrite    = 1'b0;
    ctl.memwrite   = 1'b0;
    ctl.irwrite    = 1'b0;
    ctl.regwrite   = 1'b0;
    ctl.alusrca    = 1'b0;
    ctl.alusrcb    = SRCB_B;
    ctl.branch     = 1'b0;
    ctl.iord       = 1'b0;
    ctl.memtoreg   = 1'b0;
    ctl.regdst     = 1'b0;
    ctl.zeroext    = 1'b0;
    ctl.pcsrc      = PCSRC_ALU;
    ctl.aluop      = ALUOP_ADD;
    ctl.illegal_op = 1'b0;
    case (state_q)
      FETCH: begin
        ctl.pcwrite = 1'b1;
        ctl.irwrite = 1'b1;
        ctl.alusrcb = SRCB_FOUR;
      end
      DECODE: begin
        ctl.alusrcb    = SRCB_IMMSH;
        ctl.illegal_op = ~op_supported(ctl.op);
      end
      MEMADR: begin
        ctl.alusrca = 1'b1;
        ctl.alusrcb = SRCB_IMM;
      end
      MEMRD:   ctl.iord = 1'b1;
      MEMWB: begin
        ctl.regwrite = 1'b1;
        ctl.memtoreg = 1'b1;
      end
      MEMWR: begin
        ctl.memwrite = 1'b1;
        ctl.iord     = 1'b1;
      end
      EXECUTE: begin
        ctl.alusrca = 1'b1;
        ctl.aluop   = ALUOP_FUNCT;
      end
      ALUWB: begin
        ctl.regwrite = 1'b1;
        ctl.regdst   = 1'b1;
      end
      BRANCH: begin
        ctl.alusrca = 1'b1;
        ctl.aluop   = ALUOP_SUB;
        ctl.branch  = 1'b1;
        ctl.pcsrc   = PCSRC_ALUOUT;
      end
      ADDIEX: begin
        ctl.alusrca = 1'b1;
        ctl.alusrcb = SRCB_IMM;
      end
      ANDIEX: begin
        ctl.alusrca = 1'b1;
        ctl.alusrcb = SRCB_IMM;
        ctl.aluop   = ALUOP_AND;
        ctl.zeroext = 1'b1;
      end
      IMMWB:   ctl.regwrite = 1'b1;
      JUMP: begin
        ctl.pcwrite = 1'b1;
        ctl.pcsrc   = PCSRC_JUMP;
      end
      default: ;
    endcase
  end

  assign ctl.state = state_q;

endmodule
